// File: rtl/wallace_pkg.sv
//==============================================================================
// Module   : wallace_pkg
// Purpose  : Shared widths, FSM state type and carry-save helper for the
//            Wallace-tree accumulation sequencer.
// Revision : 1.0
//==============================================================================
`default_nettype none

package wallace_pkg;

    localparam int OP_W          = 3;
    localparam int OPS_PER_CHUNK = 12;
    localparam int CHUNK_W       = OP_W * OPS_PER_CHUNK;
    localparam int TREE_W        = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TREE_W-1:0] sum;
        logic [TREE_W-1:0] carry;
    } csa_t;

    // 3:2 compressor; the carry MSB is dropped because the tree total never exceeds 84
    function automatic csa_t csa3(input logic [TREE_W-1:0] a,
                                  input logic [TREE_W-1:0] b,
                                  input logic [TREE_W-1:0] c);
        csa_t              r;
        logic [TREE_W-1:0] maj;
        maj     = (a & b) | (a & c) | (b & c);
        r.sum   = a ^ b ^ c;
        r.carry = {maj[TREE_W-2:0], 1'b0};
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wallace_3bit_12.sv
//==============================================================================
// Module   : wallace_3bit_12
// Purpose  : Combinational Wallace tree summing twelve unsigned 3-bit operands.
// Revision : 1.0
//==============================================================================
`default_nettype none

module wallace_3bit_12
    import wallace_pkg::*;
(
    input  logic [CHUNK_W-1:0] op,
    output logic [TREE_W-1:0]  res
);

    logic [TREE_W-1:0] w_ext [OPS_PER_CHUNK];
    csa_t              w_l1  [4];
    csa_t              w_l2a, w_l2b, w_l3a, w_l3b, w_l4, w_l5;

    generate
        for (genvar j = 0; j < OPS_PER_CHUNK; j++) begin : g_ext
            assign w_ext[j] = {{(TREE_W-OP_W){1'b0}}, op[j*OP_W +: OP_W]};
        end
        for (genvar i = 0; i < 4; i++) begin : g_l1
            assign w_l1[i] = csa3(w_ext[3*i], w_ext[3*i+1], w_ext[3*i+2]);
        end
    endgenerate

    // 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add
    assign w_l2a = csa3(w_l1[0].sum,   w_l1[0].carry, w_l1[1].sum);
    assign w_l2b = csa3(w_l1[1].carry, w_l1[2].sum,   w_l1[2].carry);
    assign w_l3a = csa3(w_l2a.sum,     w_l2a.carry,   w_l2b.sum);
    assign w_l3b = csa3(w_l2b.carry,   w_l1[3].sum,   w_l1[3].carry);
    assign w_l4  = csa3(w_l3a.sum,     w_l3a.carry,   w_l3b.sum);
    assign w_l5  = csa3(w_l4.sum,      w_l4.carry,    w_l3b.carry);

    assign res = w_l5.sum + w_l5.carry;

endmodule

`default_nettype wire

// File: rtl/wallace_accum_seq.sv
//==============================================================================
// Module   : wallace_accum_seq
// Purpose  : Time-shares one 12x3-bit Wallace tree over NUM_CHUNKS chunks and
//            accumulates the chunk sums. Option macro: WALLACE_ACCUM_PIPE_EN
//            (registers the tree output, RUN lasts one extra cycle).
// Revision : 1.0
//==============================================================================
`default_nettype none

module wallace_accum_seq
    import wallace_pkg::*;
#(
    parameter int NUM_CHUNKS = 4,
    parameter int ACC_W      = 7 + $clog2(NUM_CHUNKS)
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_ops,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic                          busy
);

`ifdef WALLACE_ACCUM_PIPE_EN
    localparam int RUN_LAST = NUM_CHUNKS;
`else
    localparam int RUN_LAST = NUM_CHUNKS - 1;
`endif
    localparam int             CNT_W    = (RUN_LAST > 0) ? $clog2(RUN_LAST + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LAST);

    state_t                        r_state, w_state_nxt;
    logic [CHUNK_W*NUM_CHUNKS-1:0] r_buf;
    logic [CNT_W-1:0]              r_cnt;
    logic [ACC_W-1:0]              r_acc;
    logic [ACC_W-1:0]              r_sum;
    logic                          r_out_valid;
    logic [CHUNK_W-1:0]            w_chunk;
    logic [TREE_W-1:0]             w_tree;
    logic [TREE_W-1:0]             w_add;
    logic [ACC_W-1:0]              w_acc_nxt;

    always_comb begin
        w_chunk = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_chunk = r_buf[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    wallace_3bit_12 u_tree (
        .op  (w_chunk),
        .res (w_tree)
    );

`ifdef WALLACE_ACCUM_PIPE_EN
    logic [TREE_W-1:0] r_tree;
    logic              r_pvld;

    // r_pvld marks r_tree as holding a real chunk sum; it is low on the first RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tree <= '0;
            r_pvld <= 1'b0;
        end else begin
            r_tree <= w_tree;
            r_pvld <= (r_state == RUN) && (r_cnt != CNT_LAST);
        end
    end

    assign w_add = r_pvld ? r_tree : '0;
`else
    assign w_add = w_tree;
`endif

    assign w_acc_nxt = r_acc + ACC_W'(w_add);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_buf <= in_ops;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == CNT_LAST) begin
                        r_sum       <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_wallace_accum_seq.sv
//==============================================================================
// Module   : tb_wallace_accum_seq
// Purpose  : Directed self-checking bench for wallace_accum_seq (4-chunk and
//            1-chunk instances).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_wallace_accum_seq;

    localparam int N = 4;
    localparam int W = 36 * N;
`ifdef WALLACE_ACCUM_PIPE_EN
    localparam int PIPE_X = 1;
`else
    localparam int PIPE_X = 0;
`endif
    localparam int LAT  = N + 1 + PIPE_X;
    localparam int LAT1 = 2 + PIPE_X;
    localparam int GAP  = N + 2 + PIPE_X;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_ops = '0;
    logic         in_ready, out_valid, busy;
    logic [8:0]   out_sum;

    logic         in_valid1 = 1'b0;
    logic         out_ready1 = 1'b0;
    logic [35:0]  in_ops1 = '0;
    logic         in_ready1, out_valid1, busy1;
    logic [6:0]   out_sum1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wallace_accum_seq #(.NUM_CHUNKS(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    wallace_accum_seq #(.NUM_CHUNKS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_ops(in_ops1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .busy(busy1)
    );

    function automatic logic [W-1:0] fill(input logic [2:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < 12*N; j++) r[3*j +: 3] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] jmod();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 12; j++) r[36*k + 3*j +: 3] = 3'(j % 8);
        return r;
    endfunction

    function automatic int golden(input logic [W-1:0] ops);
        int s;
        s = 0;
        for (int j = 0; j < 12*N; j++) s += int'(ops[3*j +: 3]);
        return s;
    endfunction

    // Presents ops and returns #1 after the accept edge
    task automatic start_txn(input logic [W-1:0] ops);
        int g;
        g = 0;
        in_ops   = ops;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // lat counts clock edges with the accept edge as 1
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_sum !== 9'd0) begin fails++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat;
        out_ready = 1'b1;
        start_txn('0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL zero_busy: got %b expected 1", busy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready_run: got %b expected 0", in_ready); end
        wait_valid(lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
        tests++; if (out_sum !== 9'd0) begin fails++; $display("FAIL zero_sum: got %0d expected 0", out_sum); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_pulse: got %b expected 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_back_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_sums();
        logic [W-1:0] v [4];
        int           e [4];
        logic [W-1:0] r;
        int           lat;
        v[0] = fill(3'd7);  e[0] = 336;
        v[1] = '0;
        for (int k = 0; k < N; k++) v[1][36*k +: 3] = 3'd5;
        e[1] = 20;
        v[2] = jmod();      e[2] = 136;
        v[3] = fill(3'd1);  e[3] = 48;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_txn(v[i]);
            wait_valid(lat);
            tests++; if (out_valid !== 1'b1 || out_sum !== 9'(e[i])) begin
                fails++; $display("FAIL sum_directed_%0d: got %0d (valid %b) expected %0d", i, out_sum, out_valid, e[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 12*N; j++) r[3*j +: 3] = 3'($urandom_range(0, 7));
            start_txn(r);
            wait_valid(lat);
            tests++; if (out_valid !== 1'b1 || out_sum !== 9'(golden(r))) begin
                fails++; $display("FAIL sum_random_%0d: got %0d expected %0d", i, out_sum, golden(r));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_txn(fill(3'd7));
        wait_valid(lat);
        tests++; if (out_sum !== 9'd336) begin fails++; $display("FAIL hold_sum_initial: got %0d expected 336", out_sum); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_ops   = fill(3'd1);
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || out_sum !== 9'd336 || in_ready !== 1'b0) begin
                fails++; $display("FAIL hold_cycle_%0d: got valid %b sum %0d in_ready %b expected 1 336 0", i, out_valid, out_sum, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_no_accept: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_in_run();
        int lat;
        out_ready = 1'b1;
        start_txn(fill(3'd7));
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || out_sum !== 9'd0) begin
            fails++; $display("FAIL async_reset_out: got valid %b sum %0d expected 0 0", out_valid, out_sum);
        end
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL async_reset_state: got in_ready %b busy %b expected 1 0", in_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        start_txn(fill(3'd1));
        wait_valid(lat);
        tests++; if (out_valid !== 1'b1 || out_sum !== 9'd48 || lat != LAT) begin
            fails++; $display("FAIL after_reset_txn: got sum %0d lat %0d expected 48 %0d", out_sum, lat, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vec [3];
        int           e [3];
        int           acc_c [3];
        int           n, m;
        vec[0] = fill(3'd2); e[0] = 96;
        vec[1] = jmod();     e[1] = 136;
        vec[2] = '0;
        for (int j = 0; j < 12; j++) vec[2][36*(N-1) + 3*j +: 3] = 3'd7;
        e[2] = 84;
        acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
        n = 0; m = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 60 && m < 3; c++) begin
            if (out_valid) begin
                tests++; if (out_sum !== 9'(e[m])) begin
                    fails++; $display("FAIL b2b_sum_%0d: got %0d expected %0d", m, out_sum, e[m]);
                end
                m++;
            end
            if (in_ready && n < 3) begin
                in_ops   = vec[n];
                acc_c[n] = c;
                n++;
            end else begin
                in_ops = fill(3'd7);
                if (in_ready) in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++; if (m != 3 || n != 3) begin fails++; $display("FAIL b2b_count: got %0d outputs %0d accepts expected 3 3", m, n); end
        tests++; if (acc_c[1] - acc_c[0] != GAP || acc_c[2] - acc_c[1] != GAP) begin
            fails++; $display("FAIL b2b_spacing: got %0d %0d expected %0d", acc_c[1] - acc_c[0], acc_c[2] - acc_c[1], GAP);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_chunk();
        int lat;
        in_ops1    = '1;
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        tests++; if (lat != LAT1) begin fails++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT1); end
        tests++; if (out_sum1 !== 7'd84) begin fails++; $display("FAIL single_sum: got %0d expected 84", out_sum1); end
        @(posedge clk); #1;
        tests++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            fails++; $display("FAIL single_release: got valid %b in_ready %b expected 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sums();
        test_backpressure();
        test_reset_in_run();
        test_back_to_back();
        test_single_chunk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
